// File: rtl/bt656_capture_ctrl.sv
// Gates a BT.656 receiver stream into whole, well-formed frames for DMA; zero-cycle pass-through.
// Forwarded beats see s_tready = m_tready; discarded or errored beats are always accepted.
module bt656_capture_ctrl #(
  parameter int H_W  = 12,
  parameter int V_W  = 11,
  parameter int TO_W = 24,
  parameter int DW   = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            continuous_i,
  input  logic [H_W-1:0]  h_size_i,
  input  logic [V_W-1:0]  v_size_i,
  input  logic [TO_W-1:0] timeout_i,
  input  logic [DW-1:0]   s_tdata,
  input  logic            s_tvalid,
  input  logic            s_tuser,
  input  logic            s_tlast,
  output logic            s_tready,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tuser,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic            rx_en_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [2:0]      err_o,
  output logic [15:0]     frame_cnt_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;

  logic [1:0]      state_q;
  logic [H_W-1:0]  pix_q, h_q;
  logic [V_W-1:0]  line_q, v_q;
  logic [TO_W-1:0] to_q;
  logic            cont_q, stop_pend_q, done_q;
  logic [2:0]      err_q;
  logic [15:0]     frame_cnt_q;

  logic            in_wait, in_cap, frame_beat, len_err, sof_err, bad_beat;
  logic            accept, good_acc, err_acc, line_end, frame_end;
  logic            timeout_hit, stop_now, cont_eff;
  logic [H_W-1:0]  h_eff, pix_next;
  logic [V_W-1:0]  v_eff;
  logic [TO_W-1:0] to_next;

  assign in_wait = (state_q == ST_WAIT_SOF);
  assign in_cap  = (state_q == ST_CAPTURE);

  // The SOF beat is judged against live config, since it is the beat that latches it.
  assign frame_beat = in_cap || (in_wait && s_tuser);
  assign h_eff      = in_cap ? h_q : h_size_i;
  assign v_eff      = in_cap ? v_q : v_size_i;
  assign cont_eff   = in_cap ? cont_q : continuous_i;
  assign pix_next   = in_cap ? (pix_q + H_W'(1)) : H_W'(1);

  assign len_err  = frame_beat && (s_tlast ? (pix_next != h_eff) : (pix_next == h_eff));
  assign sof_err  = in_cap && s_tuser;
  assign bad_beat = len_err || sof_err;

  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    if (frame_beat && !bad_beat) begin
      s_tready = m_tready;
      m_tvalid = s_tvalid;
    end else if (in_wait || in_cap) begin
      s_tready = 1'b1;
    end
  end

  assign m_tdata = s_tdata;
  assign m_tuser = s_tuser;
  assign m_tlast = s_tlast;

  assign accept      = s_tvalid && s_tready;
  assign good_acc    = accept && frame_beat && !bad_beat;
  assign err_acc     = accept && frame_beat && bad_beat;
  assign line_end    = good_acc && s_tlast;
  assign frame_end   = line_end && (line_q == (v_eff - V_W'(1)));
  assign to_next     = to_q + TO_W'(1);
  assign timeout_hit = !accept && (timeout_i != '0) && (to_next == timeout_i);
  assign stop_now    = stop_pend_q || stop_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      pix_q       <= '0;
      line_q      <= '0;
      h_q         <= '0;
      v_q         <= '0;
      to_q        <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            to_q        <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            stop_pend_q <= 1'b0;
            if ((h_size_i == '0) || (v_size_i == '0)) begin
              err_q <= 3'b001;
            end else begin
              err_q   <= '0;
              state_q <= ST_WAIT_SOF;
            end
          end
        end
        default: begin
          to_q <= accept ? '0 : to_next;
          if (good_acc && in_wait) begin
            h_q    <= h_size_i;
            v_q    <= v_size_i;
            cont_q <= continuous_i;
          end
          // A stop that arrives once a frame has begun waits for that frame to finish or abort.
          if (stop_i && (in_cap || good_acc)) stop_pend_q <= 1'b1;

          if (timeout_hit) begin
            err_q[2]    <= 1'b1;
            state_q     <= ST_IDLE;
            pix_q       <= '0;
            line_q      <= '0;
            stop_pend_q <= 1'b0;
          end else if (err_acc) begin
            err_q[1] <= err_q[1] | sof_err;
            err_q[0] <= err_q[0] | len_err;
            pix_q    <= '0;
            line_q   <= '0;
            if (stop_now) begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= ST_WAIT_SOF;
            end
          end else if (frame_end) begin
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            pix_q       <= '0;
            line_q      <= '0;
            if (cont_eff && !stop_now) begin
              state_q <= ST_WAIT_SOF;
            end else begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end
          end else if (line_end) begin
            pix_q   <= '0;
            line_q  <= line_q + V_W'(1);
            state_q <= ST_CAPTURE;
          end else if (good_acc) begin
            pix_q   <= pix_next;
            state_q <= ST_CAPTURE;
          end else if (in_wait && stop_i) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign rx_en_o     = busy_o;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Randomized bench for bt656_capture_ctrl: a beat-level frame model predicts forwarded beats and error flags.
module tb_bt656_capture_ctrl;
  localparam int H_W  = 12;
  localparam int V_W  = 11;
  localparam int TO_W = 24;
  localparam int DW   = 16;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          usr;
    logic          lst;
  } beat_t;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            start_i = 1'b0;
  logic            stop_i = 1'b0;
  logic            continuous_i = 1'b0;
  logic [H_W-1:0]  h_size_i = 12'd4;
  logic [V_W-1:0]  v_size_i = 11'd2;
  logic [TO_W-1:0] timeout_i = '0;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tuser = 1'b0;
  logic            s_tlast = 1'b0;
  logic            s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tuser;
  logic            m_tlast;
  logic            m_tready = 1'b1;
  logic            rx_en_o;
  logic            busy_o;
  logic            done_o;
  logic [2:0]      err_o;
  logic [15:0]     frame_cnt_o;

  bt656_capture_ctrl #(.H_W(H_W), .V_W(V_W), .TO_W(TO_W), .DW(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .h_size_i(h_size_i), .v_size_i(v_size_i),
    .timeout_i(timeout_i), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready), .rx_en_o(rx_en_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int    n_chk = 0;
  int    n_fail = 0;
  int    fwd_cnt = 0;
  int    done_cnt = 0;
  bit    gap_en = 1'b0;
  bit    rdy_rand = 1'b0;
  beat_t stim_q[$];
  beat_t exp_q[$];
  beat_t mon_exp;
  bit    m_cap;
  int    m_pix, m_line, exp_frames;
  logic [2:0] exp_err;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame rules applied beat by beat in stream (acceptance) order.
  task automatic model_walk(input int h, input int v);
    beat_t b;
    int    n;
    bit    sof_bad, len_bad;
    foreach (stim_q[i]) begin
      b = stim_q[i];
      if (!m_cap && !b.usr) continue;
      sof_bad = m_cap && b.usr;
      n       = m_cap ? m_pix + 1 : 1;
      len_bad = b.lst ? (n != h) : (n == h);
      if (sof_bad || len_bad) begin
        exp_err[1] = exp_err[1] | sof_bad;
        exp_err[0] = exp_err[0] | len_bad;
        m_cap = 1'b0; m_pix = 0; m_line = 0;
      end else begin
        exp_q.push_back(b);
        m_cap = 1'b1; m_pix = n;
        if (b.lst) begin
          m_pix = 0;
          m_line++;
          if (m_line == v) begin
            exp_frames++;
            m_cap = 1'b0; m_line = 0;
          end
        end
      end
    end
  endtask

  task automatic push_junk(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat = 16'($urandom); b.usr = 1'b0; b.lst = 1'($urandom_range(0, 1));
      stim_q.push_back(b);
    end
  endtask

  // cut = index of the beat to corrupt (frame ends there); how bit0 flips tlast, bit1 sets tuser.
  task automatic push_frame(input int h, input int v, input int cut, input int how);
    beat_t b;
    int    k;
    k = 0;
    for (int l = 0; l < v; l++) begin
      for (int p = 1; p <= h; p++) begin
        b.dat = 16'($urandom); b.usr = (l == 0 && p == 1); b.lst = (p == h);
        if (k == cut) begin
          if (how[0]) b.lst = !b.lst;
          if (how[1]) b.usr = 1'b1;
          stim_q.push_back(b);
          return;
        end
        stim_q.push_back(b);
        k++;
      end
    end
  endtask

  task automatic send_beat(input beat_t b);
    int cyc;
    bit acc;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    s_tdata = b.dat; s_tuser = b.usr; s_tlast = b.lst; s_tvalid = 1'b1;
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 200) begin
      @(negedge clk_i);
      acc = s_tready;
      @(posedge clk_i); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    chk_eq("beat_accept", 32'(acc), 1);
  endtask

  task automatic send_n(input int n);
    beat_t b;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      b = stim_q.pop_front();
      send_beat(b);
    end
  endtask

  task automatic run_stream(input int h, input int v);
    model_walk(h, v);
    send_n(stim_q.size());
  endtask

  task automatic do_start();
    m_cap = 1'b0; m_pix = 0; m_line = 0; exp_err = '0;
    @(posedge clk_i); #1; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk_i); #1; stop_i = 1'b1;
    @(posedge clk_i); #1; stop_i = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (m_tvalid && m_tready) begin
      fwd_cnt++;
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk_eq("fwd_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(mon_exp));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0, c0, kind, h, v, cut;
    exp_frames = 0;
    exp_err = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_eq("rst_busy", 32'(busy_o), 0);
    chk_eq("rst_rx_en", 32'(rx_en_o), 0);
    chk_eq("rst_s_tready", 32'(s_tready), 0);
    chk_eq("rst_m_tvalid", 32'(m_tvalid), 0);
    chk_eq("rst_done", 32'(done_o), 0);
    chk_eq("rst_err", 32'(err_o), 0);
    chk_eq("rst_frame_cnt", 32'(frame_cnt_o), 0);
    rstn_i = 1'b1;
    settle();
    chk_eq("idle_after_rst", 32'(busy_o), 0);

    // Single frame with leading junk, downstream always ready.
    h_size_i = 4; v_size_i = 2; continuous_i = 1'b0;
    do_start();
    chk_eq("start_busy", 32'(busy_o), 1);
    chk_eq("start_rx_en", 32'(rx_en_o), 1);
    f0 = fwd_cnt; d0 = done_cnt;
    push_junk(3);
    push_frame(4, 2, -1, 0);
    run_stream(4, 2);
    chk_eq("single_done_pulse", 32'(done_o), 1);
    chk_eq("single_idle", 32'(busy_o), 0);
    settle();
    chk_eq("single_done_low", 32'(done_o), 0);
    chk_eq("single_fwd", 32'(fwd_cnt - f0), 8);
    chk_eq("single_done_cnt", 32'(done_cnt - d0), 1);
    chk_eq("single_frame_cnt", 32'(frame_cnt_o), 1);
    chk_eq("single_err", 32'(err_o), 32'(exp_err));

    // Three back-to-back frames, continuous, random downstream stalls and source gaps.
    continuous_i = 1'b1; rdy_rand = 1'b1; gap_en = 1'b1;
    do_start();
    f0 = fwd_cnt; d0 = done_cnt; c0 = frame_cnt_o;
    for (int i = 0; i < 3; i++) push_frame(4, 2, -1, 0);
    run_stream(4, 2);
    settle();
    chk_eq("cont_fwd", 32'(fwd_cnt - f0), 24);
    chk_eq("cont_frames", 32'(frame_cnt_o - 16'(c0)), 3);
    chk_eq("cont_done_cnt", 32'(done_cnt - d0), 3);
    chk_eq("cont_busy", 32'(busy_o), 1);
    chk_eq("cont_exp_drained", 32'(exp_q.size()), 0);
    do_stop();
    chk_eq("cont_stop_idle", 32'(busy_o), 0);

    // Early tlast on beat 3, then a clean frame.
    rdy_rand = 1'b0; gap_en = 1'b0;
    do_start();
    f0 = fwd_cnt; c0 = frame_cnt_o;
    push_frame(4, 2, 2, 1);
    run_stream(4, 2);
    chk_eq("len_err_bits", 32'(err_o), 32'b001);
    chk_eq("len_err_wait_sof", 32'(busy_o), 1);
    push_frame(4, 2, -1, 0);
    run_stream(4, 2);
    settle();
    chk_eq("len_err_fwd", 32'(fwd_cnt - f0), 10);
    chk_eq("len_err_recover", 32'(frame_cnt_o - 16'(c0)), 1);
    do_stop();

    // SOF on beat 6 mid-frame, then a clean frame.
    do_start();
    f0 = fwd_cnt; c0 = frame_cnt_o;
    push_frame(4, 2, 5, 2);
    run_stream(4, 2);
    chk_eq("sof_err_bits", 32'(err_o), 32'b010);
    chk_eq("sof_err_wait_sof", 32'(busy_o), 1);
    push_frame(4, 2, -1, 0);
    run_stream(4, 2);
    settle();
    chk_eq("sof_err_fwd", 32'(fwd_cnt - f0), 13);
    chk_eq("sof_err_recover", 32'(frame_cnt_o - 16'(c0)), 1);
    do_stop();

    // Randomized geometry and corruption, continuous capture.
    rdy_rand = 1'b1; gap_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      h = $urandom_range(1, 5); v = $urandom_range(1, 3);
      h_size_i = H_W'(h); v_size_i = V_W'(v);
      do_start();
      d0 = done_cnt; c0 = exp_frames;
      for (int s = 0; s < 6; s++) begin
        kind = $urandom_range(0, 2);
        if (kind == 0) push_junk($urandom_range(1, 3));
        else if (kind == 1 || h * v < 2) push_frame(h, v, -1, 0);
        else begin
          cut = $urandom_range(1, h * v - 1);
          push_frame(h, v, cut, $urandom_range(1, 3));
        end
      end
      run_stream(h, v);
      settle();
      chk_eq("rand_err", 32'(err_o), 32'(exp_err));
      chk_eq("rand_frame_cnt", 32'(frame_cnt_o), 32'(16'(exp_frames)));
      chk_eq("rand_done_cnt", 32'(done_cnt - d0), 32'(exp_frames - c0));
      chk_eq("rand_exp_drained", 32'(exp_q.size()), 0);
      do_stop();
      chk_eq("rand_stop_idle", 32'(busy_o), 0);
    end

    // Timeout with no input at all.
    rdy_rand = 1'b0; gap_en = 1'b0;
    h_size_i = 4; v_size_i = 2; continuous_i = 1'b0; timeout_i = 100;
    do_start();
    repeat (99) @(posedge clk_i);
    #1;
    chk_eq("to_before_err", 32'(err_o), 0);
    chk_eq("to_before_busy", 32'(busy_o), 1);
    @(posedge clk_i); #1;
    chk_eq("to_err", 32'(err_o), 32'b100);
    chk_eq("to_idle", 32'(busy_o), 0);
    chk_eq("to_rx_en", 32'(rx_en_o), 0);
    timeout_i = 0;

    // Stop during line 1 of continuous capture: frame still completes.
    continuous_i = 1'b1;
    do_start();
    d0 = done_cnt;
    push_frame(4, 2, -1, 0);
    model_walk(4, 2);
    send_n(2);
    do_stop();
    chk_eq("stop_pending_busy", 32'(busy_o), 1);
    send_n(6);
    chk_eq("stop_done_pulse", 32'(done_o), 1);
    chk_eq("stop_idle", 32'(busy_o), 0);
    chk_eq("stop_err", 32'(err_o), 0);
    settle();
    chk_eq("stop_done_cnt", 32'(done_cnt - d0), 1);

    // Zero geometry refuses to start.
    h_size_i = 0;
    do_start();
    chk_eq("zero_h_err", 32'(err_o), 32'b001);
    chk_eq("zero_h_idle", 32'(busy_o), 0);
    h_size_i = 4;

    // Reset in the middle of a frame with a beat on offer.
    do_start();
    push_frame(4, 2, -1, 0);
    while (stim_q.size() > 4) void'(stim_q.pop_back());
    model_walk(4, 2);
    send_n(3);
    mon_exp = stim_q.pop_front();
    s_tdata = mon_exp.dat; s_tuser = mon_exp.usr; s_tlast = mon_exp.lst; s_tvalid = 1'b1;
    #1;
    chk_eq("pre_rst_offer", 32'(m_tvalid), 1);
    rstn_i = 1'b0;
    #1;
    exp_q.delete();
    exp_frames = 0;
    chk_eq("mid_rst_m_tvalid", 32'(m_tvalid), 0);
    chk_eq("mid_rst_s_tready", 32'(s_tready), 0);
    chk_eq("mid_rst_busy", 32'(busy_o), 0);
    chk_eq("mid_rst_rx_en", 32'(rx_en_o), 0);
    chk_eq("mid_rst_err", 32'(err_o), 0);
    chk_eq("mid_rst_frame_cnt", 32'(frame_cnt_o), 0);
    chk_eq("mid_rst_done", 32'(done_o), 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk_eq("post_rst_m_tvalid", 32'(m_tvalid), 0);
    chk_eq("post_rst_idle", 32'(busy_o), 0);
    s_tvalid = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bt656_capture_ctrl.md
BT656_CAPTURE_CTRL -- requirements
Module: bt656_capture_ctrl

Interface
REQ-001 SHALL have parameter H_W, default 12, pixel-counter and h_size width.
REQ-002 SHALL have parameter V_W, default 11, line-counter and v_size width.
REQ-003 SHALL have parameter TO_W, default 24, timeout-counter width.
REQ-004 SHALL have parameter DW, default 16, stream data width.
REQ-005 SHALL have ports as follows; one clock; reset asynchronous, active-low.
- clk_i  in  1  sole clock.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  capture request pulse.
- stop_i  in  1  stop request pulse.
- continuous_i  in  1  1 = re-arm after each frame.
- h_size_i  in  H_W  pixels (beats) per line.
- v_size_i  in  V_W  lines per frame.
- timeout_i  in  TO_W  idle-beat limit in cycles; 0 disables.
- s_tdata/s_tvalid/s_tuser/s_tlast  in  DW/1/1/1  stream from BT.656 receiver; tuser = SOF, tlast = EOL.
- s_tready  out  1  upstream ready.
- m_tdata/m_tvalid/m_tuser/m_tlast  out  DW/1/1/1  stream to DMA.
- m_tready  in  1  downstream ready.
- rx_en_o  out  1  receiver enable.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  3  sticky {timeout, sof_err, len_err}.
- frame_cnt_o  out  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-006 SHALL implement states IDLE, WAIT_SOF, CAPTURE.
REQ-007 IDLE: rx_en_o=0, s_tready=0, m_tvalid=0; start_i -> WAIT_SOF next cycle, clears err_o and timeout counter.
REQ-008 WAIT_SOF: rx_en_o=1, s_tready=1, m_tvalid=0; non-SOF beats discarded; accepted beat with s_tuser=1 -> CAPTURE, same beat forwarded.
REQ-009 SOF beat in WAIT_SOF SHALL be forwarded combinationally: s_tready=m_tready for that beat, transition only on s_tvalid&&m_tready.
REQ-010 CAPTURE: combinational pass-through, m_t* = s_t*, s_tready = m_tready; zero-cycle latency, no buffering.
REQ-011 Pixel counter SHALL count accepted beats in current line, starting at 1 for first beat; reset to 0 after accepted tlast.
REQ-012 Line counter SHALL increment on each accepted tlast; frame ends on accepted tlast when line counter = v_size_i-1.
REQ-013 Frame end SHALL pulse done_o one cycle after the accepting edge, increment frame_cnt_o, reset counters, go to WAIT_SOF if continuous_i=1 and no stop pending, else IDLE.
REQ-014 len_err: beat with tlast and pixel count != h_size_i, or beat without tlast whose pixel count = h_size_i; error beat SHALL be consumed (s_tready=1) and not forwarded (m_tvalid=0), state -> WAIT_SOF, counters cleared.
REQ-015 sof_err: s_tuser=1 beat in CAPTURE after first beat; same drop/abort as REQ-014.
REQ-016 Simultaneous len_err and sof_err on one beat SHALL set both bits.
REQ-017 Timeout counter SHALL increment every cycle in WAIT_SOF/CAPTURE without an accepted beat, clear on accepted beat; reaching timeout_i (nonzero) sets err_o[2], state -> IDLE.
REQ-018 stop_i in WAIT_SOF SHALL go to IDLE next cycle; in CAPTURE SHALL latch pending-stop and go to IDLE at frame end or abort; ignored in IDLE.
REQ-019 start_i while busy SHALL be ignored; start_i and stop_i same cycle in IDLE: start wins, stop ignored.
REQ-020 Configuration inputs SHALL be sampled at each WAIT_SOF->CAPTURE transition and held for the frame.
REQ-021 h_size_i=0 or v_size_i=0 SHALL set len_err on start, remain IDLE.

Reset
REQ-022 rstn_i low SHALL asynchronously force IDLE, all counters 0, rx_en_o=0, busy_o=0, done_o=0, err_o=0, frame_cnt_o=0, s_tready=0, m_tvalid=0.
REQ-023 Reset mid-frame SHALL abandon the frame without forwarding further beats; after release block waits for start_i.

Verification
REQ-024 h=4,v=2, single, m_tready=1: start, 3 junk beats, then SOF frame of 8 beats -> junk dropped, 8 beats forwarded with tuser on beat 1, tlast on beats 4/8, done_o pulse, frame_cnt_o=1, IDLE.
REQ-025 Continuous, 3 frames, m_tready toggling 50% -> 24 beats forwarded in order, no loss/duplication, frame_cnt_o=3, busy_o remains 1.
REQ-026 h=4: line with tlast on beat 3 -> err_o=3'b001, beat 3 not forwarded, WAIT_SOF; next good frame captured.
REQ-027 SOF on beat 6 mid-frame -> err_o=3'b010, state WAIT_SOF, following SOF captured normally.
REQ-028 timeout_i=100, no input after start -> err_o=3'b100 at cycle 100, IDLE, rx_en_o=0.
REQ-029 stop_i during line 1 of continuous capture -> frame completes, done_o pulses, IDLE; rstn_i low mid-frame -> all outputs at reset values immediately.
